// File: rtl/tri_pkg.sv
// Shared types for the triangle issue arbiter: FSM encoding and packed-triangle layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t, CW_DEF, TRI_FIELDS, per-coordinate field indices (bit offset = index*CW).
package tri_pkg;

    localparam int CW_DEF     = 3;
    localparam int TRI_FIELDS = 6;

    // Field order inside a packed triangle, counted from the LSB.
    localparam int X1_FLD = 0;
    localparam int Y1_FLD = 1;
    localparam int X2_FLD = 2;
    localparam int Y2_FLD = 3;
    localparam int X3_FLD = 4;
    localparam int Y3_FLD = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_V1   = 3'd1,
        S_V2   = 3'd2,
        S_V3   = 3'd3,
        S_WAIT = 3'd4
    } state_t;

endpackage

// File: rtl/tri_issue_arb_if.sv
// Bundle between two triangle requesters, the rasterizer and the issue arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/gnt per requester; busy from the rasterizer stalls new grants.
// Ports: req0/tri0_dat/gnt0, req1/tri1_dat/gnt1, busy, nt, xo, yo, err.
//   master = requesters + rasterizer side, slave = arbiter side.
interface tri_issue_arb_if
    import tri_pkg::*;
#(
    parameter int CW = CW_DEF
);

    logic                     req0;
    logic [TRI_FIELDS*CW-1:0] tri0_dat;
    logic                     gnt0;
    logic                     req1;
    logic [TRI_FIELDS*CW-1:0] tri1_dat;
    logic                     gnt1;
    logic                     busy;
    logic                     nt;
    logic [CW-1:0]            xo;
    logic [CW-1:0]            yo;
    logic                     err;

    modport master (
        output req0, tri0_dat, req1, tri1_dat, busy,
        input  gnt0, gnt1, nt, xo, yo, err
    );

    modport slave (
        input  req0, tri0_dat, req1, tri1_dat, busy,
        output gnt0, gnt1, nt, xo, yo, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker producing a one-hot grant.
// Latency: combinational.
// Backpressure: en=0 forces no grant.
// Ports: req[1:0] requests, last = index granted last time, en = grant allowed, gnt[1:0] one-hot.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            // On a tie the requester that did not win last time gets it.
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/tri_issue_arb.sv
// Arbitrates two triangle requesters and streams the winner's three vertices to a rasterizer.
// Latency: grant in cycle N (combinational), nt + vertex 1 in N+1, vertex 2 in N+2, vertex 3 in N+3.
// Backpressure: no grant while busy=1 or while a triangle is in flight; WAIT until busy rises and falls.
// Ports: clk, reset (sync, active-low), bus (tri_issue_arb_if.slave).
// Optional: define TRIARB_TIMEOUT_EN to add a WAIT watchdog (TO_CYCLES) that pulses err and returns to IDLE.
module tri_issue_arb
    import tri_pkg::*;
#(
    parameter int CW        = CW_DEF,
    parameter int TO_CYCLES = 15
) (
    input  logic           clk,
    input  logic           reset,
    tri_issue_arb_if.slave bus
);

    localparam int TW = TRI_FIELDS * CW;

    // A zero-length watchdog window is meaningless; reject it at elaboration.
    if (TO_CYCLES < 1) begin : g_to_range
        $error("tri_issue_arb: TO_CYCLES must be at least 1");
    end

    state_t        state;
    logic [TW-1:0] tri_q;
    logic          last_q;
    logic          seen_q;
    logic          run_ok_q;   // low for the first cycle after reset release: no grant yet
    logic          arb_en;
    logic [1:0]    gnt;
    logic [TW-1:0] sel_dat;
    logic [CW-1:0] xo_c;
    logic [CW-1:0] yo_c;

`ifdef TRIARB_TIMEOUT_EN
    localparam int TOW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYCLES - 1);
    logic [TOW-1:0] to_cnt;
    logic           err_q;
`endif

    // reset is also used combinationally so grants stay low while reset is held.
    assign arb_en = reset && run_ok_q && (state == S_IDLE) && !bus.busy;

    rr_arb2 u_rr (
        .req  ({bus.req1, bus.req0}),
        .last (last_q),
        .en   (arb_en),
        .gnt  (gnt)
    );

    assign bus.gnt0 = gnt[0];
    assign bus.gnt1 = gnt[1];
    assign sel_dat  = gnt[1] ? bus.tri1_dat : bus.tri0_dat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            tri_q    <= '0;
            last_q   <= 1'b1;
            seen_q   <= 1'b0;
            run_ok_q <= 1'b0;
`ifdef TRIARB_TIMEOUT_EN
            to_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            run_ok_q <= 1'b1;
`ifdef TRIARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        tri_q  <= sel_dat;
                        last_q <= gnt[1];
                        state  <= S_V1;
                    end
                end
                S_V1: state <= S_V2;
                S_V2: state <= S_V3;
                S_V3: state <= S_WAIT;
                S_WAIT: begin
                    // Completion means busy was seen high and has now dropped;
                    // busy low on its own never ends the wait.
                    if (seen_q && !bus.busy) begin
                        state  <= S_IDLE;
                        seen_q <= 1'b0;
`ifdef TRIARB_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end else if (bus.busy) begin
                        seen_q <= 1'b1;
                    end
`ifdef TRIARB_TIMEOUT_EN
                    else begin
                        // Rasterizer never started: give up after TO_CYCLES idle WAIT cycles.
                        if (to_cnt == TO_LAST) begin
                            to_cnt <= '0;
                            err_q  <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Vertex outputs are a decode of registered state and the captured triangle.
    always_comb begin
        xo_c = '0;
        yo_c = '0;
        case (state)
            S_V1: begin
                xo_c = tri_q[X1_FLD*CW +: CW];
                yo_c = tri_q[Y1_FLD*CW +: CW];
            end
            S_V2: begin
                xo_c = tri_q[X2_FLD*CW +: CW];
                yo_c = tri_q[Y2_FLD*CW +: CW];
            end
            S_V3: begin
                xo_c = tri_q[X3_FLD*CW +: CW];
                yo_c = tri_q[Y3_FLD*CW +: CW];
            end
            default: begin
                xo_c = '0;
                yo_c = '0;
            end
        endcase
    end

    assign bus.nt = (state == S_V1);
    assign bus.xo = xo_c;
    assign bus.yo = yo_c;

`ifdef TRIARB_TIMEOUT_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_tri_issue_arb.sv
// Directed bench for tri_issue_arb: arbitration order, vertex streaming, busy handshake, reset.
// Latency: checks grant in cycle N, vertices in N+1..N+3.
// Backpressure: drives busy to hold the arbiter in IDLE and WAIT.
module tb_tri_issue_arb;

    localparam int CW = 3;
    localparam logic [17:0] T_A = {3'd7, 3'd1, 3'd1, 3'd4, 3'd1, 3'd1}; // (1,1),(4,1),(1,7)
    localparam logic [17:0] T_B = {3'd0, 3'd7, 3'd6, 3'd5, 3'd3, 3'd2}; // (2,3),(5,6),(7,0)

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    tri_issue_arb_if #(.CW(CW)) bus ();

    tri_issue_arb #(.CW(CW), .TO_CYCLES(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input int nt, input int xo, input int yo,
                           input int g0, input int g1);
        chk($sformatf("%s.nt", tag), 32'(bus.nt), nt);
        chk($sformatf("%s.xo", tag), 32'(bus.xo), xo);
        chk($sformatf("%s.yo", tag), 32'(bus.yo), yo);
        chk($sformatf("%s.gnt0", tag), 32'(bus.gnt0), g0);
        chk($sformatf("%s.gnt1", tag), 32'(bus.gnt1), g1);
        chk($sformatf("%s.err", tag), 32'(bus.err), 0);
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge to sample outputs.
    task automatic smp();
        @(negedge clk);
    endtask

    // Called at the drive point of a grant cycle; returns at the drive point of the
    // next IDLE cycle after streaming three vertices and a two-cycle busy pulse.
    task automatic finish_tri(input int which, input string tag,
                              input int x1, input int y1, input int x2, input int y2,
                              input int x3, input int y3);
        cyc();
        if (which == 0) bus.req0 = 1'b0;
        else            bus.req1 = 1'b0;
        smp(); chk_out({tag, "_v1"}, 1, x1, y1, 0, 0);
        cyc(); smp(); chk_out({tag, "_v2"}, 0, x2, y2, 0, 0);
        cyc(); smp(); chk_out({tag, "_v3"}, 0, x3, y3, 0, 0);
        cyc(); bus.busy = 1'b1;
        cyc();
        cyc(); bus.busy = 1'b0;
        cyc();
    endtask

    initial begin
        logic [5:0] busy_pat;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.tri0_dat = T_A;
        bus.tri1_dat = T_B;
        bus.busy = 1'b0;

        // Reset with both requests pending: nothing granted.
        cyc(); cyc(); smp();
        chk_out("rst", 0, 0, 0, 0, 0);
        cyc(); reset = 1'b1;
        smp(); chk_out("rel1", 0, 0, 0, 0, 0);

        // Tie after reset: requester 0 first; then vertices of T_A with busy for 5 cycles.
        cyc(); smp(); chk_out("a_gnt", 0, 0, 0, 1, 0);
        cyc(); bus.req0 = 1'b0; bus.busy = 1'b1;
        smp(); chk_out("a_v1", 1, 1, 1, 0, 0);
        cyc(); smp(); chk_out("a_v2", 0, 4, 1, 0, 0);
        cyc(); smp(); chk_out("a_v3", 0, 1, 7, 0, 0);
        cyc(); smp(); chk_out("a_w1", 0, 0, 0, 0, 0);
        cyc(); smp(); chk_out("a_w2", 0, 0, 0, 0, 0);
        cyc(); bus.busy = 1'b0;
        smp(); chk_out("a_w3", 0, 0, 0, 0, 0);
        // Requester 1 held through the whole triangle is granted on return to IDLE.
        cyc(); smp(); chk_out("a_g1", 0, 0, 0, 0, 1);
        finish_tri(1, "b", 2, 3, 5, 6, 7, 0);

        // Next tie goes to requester 0, then requester 1, then 0 again.
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        smp(); chk_out("c_pair1", 0, 0, 0, 1, 0);
        finish_tri(0, "c0", 1, 1, 4, 1, 1, 7);
        smp(); chk_out("c_g1", 0, 0, 0, 0, 1);
        finish_tri(1, "c1", 2, 3, 5, 6, 7, 0);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        smp(); chk_out("c_pair2", 0, 0, 0, 1, 0);
        finish_tri(0, "c2", 1, 1, 4, 1, 1, 7);
        bus.req1 = 1'b0;

        // busy in IDLE blocks the grant until it drops.
        bus.busy = 1'b1; bus.req1 = 1'b1;
        smp(); chk_out("e_blk0", 0, 0, 0, 0, 0);
        cyc(); smp(); chk_out("e_blk1", 0, 0, 0, 0, 0);
        cyc(); bus.busy = 1'b0;
        smp(); chk_out("e_g1", 0, 0, 0, 0, 1);
        finish_tri(1, "e", 2, 3, 5, 6, 7, 0);

        // busy low 3 cycles after V3, high 2, then low: exit only after the falling edge.
        bus.req0 = 1'b1;
        smp(); chk_out("f_gnt", 0, 0, 0, 1, 0);
        cyc(); bus.req0 = 1'b0;
        smp(); chk_out("f_v1", 1, 1, 1, 0, 0);
        cyc(); cyc();
        busy_pat = 6'b011000; // applied LSB first
        for (int i = 0; i < 6; i++) begin
            cyc(); bus.busy = busy_pat[i]; bus.req1 = 1'b1;
            smp(); chk_out($sformatf("f_w%0d", i), 0, 0, 0, 0, 0);
        end
        cyc(); bus.busy = 1'b0;
        smp(); chk_out("f_g1", 0, 0, 0, 0, 1);
        finish_tri(1, "f", 2, 3, 5, 6, 7, 0);

        // busy never rises after V3.
        bus.req0 = 1'b1;
        smp(); chk_out("g_gnt", 0, 0, 0, 1, 0);
        cyc(); bus.req0 = 1'b0;
        cyc(); cyc();
`ifdef TRIARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            cyc(); bus.req1 = 1'b1;
            smp();
            chk($sformatf("g_to_err%0d", i), 32'(bus.err), (i == 15) ? 1 : 0);
            chk($sformatf("g_to_gnt%0d", i), 32'(bus.gnt1), (i == 15) ? 1 : 0);
        end
`else
        for (int i = 0; i < 40; i++) begin
            cyc(); bus.req1 = 1'b1;
            smp();
            chk($sformatf("g_hold_err%0d", i), 32'(bus.err), 0);
            chk($sformatf("g_hold_gnt%0d", i), 32'(bus.gnt1), 0);
        end
`endif

        // Reset during V2 abandons the triangle; held req0 is granted after release.
        cyc(); reset = 1'b0; bus.req1 = 1'b0; bus.req0 = 1'b1;
        cyc(); reset = 1'b1;
        smp(); chk_out("d_rel", 0, 0, 0, 0, 0);
        cyc(); smp(); chk_out("d_gnt", 0, 0, 0, 1, 0);
        cyc(); smp(); chk_out("d_v1", 1, 1, 1, 0, 0);
        cyc(); reset = 1'b0;
        smp(); chk_out("d_v2", 0, 4, 1, 0, 0);
        cyc(); smp(); chk_out("d_rst", 0, 0, 0, 0, 0);
        cyc(); reset = 1'b1;
        smp(); chk_out("d_rel2", 0, 0, 0, 0, 0);
        cyc(); smp(); chk_out("d_regnt", 0, 0, 0, 1, 0);
        finish_tri(0, "d", 1, 1, 4, 1, 1, 7);
        smp(); chk_out("d_end", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_issue_arb.md
TRI_ISSUE_ARB -- requirements
Module: tri_issue_arb

Interface
REQ-001 Parameter CW, default 3: coordinate width of each x/y value.
REQ-002 Parameter TO_CYCLES, default 15: watchdog limit in WAIT; used only when TRIARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req0  in  1  requester 0 has a triangle pending; held until gnt0.
REQ-006 tri0  in  6*CW  requester 0 triangle, packed LSB-up: x1,y1,x2,y2,x3,y3.
REQ-007 gnt0  out  1  requester 0 triangle captured this cycle.
REQ-008 req1 / tri1 / gnt1: same as REQ-005..007 for requester 1.
REQ-009 busy  in  1  rasterizer is processing a triangle.
REQ-010 nt  out  1  new-triangle strobe, coincident with vertex 1.
REQ-011 xo, yo  out  CW each  current vertex coordinates.
REQ-012 err  out  1  watchdog expiry pulse; constant 0 without TRIARB_TIMEOUT_EN.

Function
REQ-013 The block SHALL implement states IDLE, V1, V2, V3 and WAIT.
REQ-014 IDLE: when busy=0 and req0 or req1 is high, the block SHALL select one requester, drive its gnt high combinationally that cycle, capture its tri on the edge, and enter V1.
REQ-015 IDLE with busy=1: no grant, remain IDLE.
REQ-016 Arbitration SHALL be two-way round-robin: a lone request wins; on simultaneous requests the requester not granted last wins. The last-grant pointer resets to 1, so requester 0 wins first.
REQ-017 V1: nt=1, xo/yo = x1/y1. V2: xo/yo = x2/y2. V3: xo/yo = x3/y3. Each state lasts exactly one cycle, advancing unconditionally.
REQ-018 Outside V1..V3: xo=0, yo=0. Outside V1: nt=0.
REQ-019 Latency: nt SHALL rise in the first cycle after the grant cycle.
REQ-020 WAIT: a seen flag SHALL set when busy=1 is sampled. The block returns to IDLE on the first cycle with seen=1 and busy=0, then clears seen.
REQ-021 busy low in every cycle after V3 SHALL keep the block in WAIT; busy=0 alone is never treated as completion.
REQ-022 req/tri changes outside IDLE SHALL be ignored.
REQ-023 gnt0 and gnt1 SHALL never be high in the same cycle, and are high only in IDLE.

Reset
REQ-024 reset=0 at a rising edge SHALL force IDLE, clear the captured triangle, clear seen and the watchdog counter, and set the last-grant pointer to 1.
REQ-025 While in reset, and in the first cycle after release: nt=0, xo=0, yo=0, gnt0=gnt1=0, err=0.
REQ-026 Reset mid-sequence (V1..WAIT) SHALL abandon the triangle; the requester is not regranted unless it still requests.

Configuration
REQ-027 Macro TRIARB_TIMEOUT_EN defined:
- a counter SHALL run in WAIT while seen=0;
- on reaching TO_CYCLES, err is pulsed for one cycle and the state returns to IDLE.
REQ-028 Macro TRIARB_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely until REQ-020; err is tied to 0.

Structure
REQ-029 Package tri_pkg SHALL hold the state encoding, the CW default, and the vertex field offsets within the packed triangle.
REQ-030 The round-robin picker SHALL be a sub-module rr_arb2: inputs req[1:0], last, en; outputs a one-hot grant.

Verification
REQ-031 req0, tri0=(1,1),(4,1),(1,7) -> gnt0 pulse; next cycles nt=1/xo=1/yo=1, then xo=4/yo=1, then xo=1/yo=7; busy high 5 cycles then low -> IDLE.
REQ-032 req0 and req1 both high after reset -> gnt0 first, gnt1 after that triangle completes; next simultaneous pair -> gnt0.
REQ-033 busy=1 in IDLE with req1 high -> no gnt1 until busy=0; gnt1 in the first IDLE cycle with busy=0.
REQ-034 reset=0 during V2 -> next cycle nt=0, xo=0, yo=0, state IDLE; after release, held req0 is granted.
REQ-035 busy never rises after V3: with TRIARB_TIMEOUT_EN -> err=1 for one cycle after 15 WAIT cycles, then IDLE; without it -> stays in WAIT, err=0.
REQ-036 busy=0 for 3 cycles after V3, then 1 for 2 cycles, then 0 -> exit to IDLE only after the falling edge of busy.
